// File: rtl/mem_access.sv
// mem_access: memory-stage data RAM with byte/half/word access and timer device decode
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RT_M,
  input  logic [4:0]  excode_M,
  input  logic        flush,
  input  logic [31:0] dev_rd0,
  input  logic [31:0] dev_rd1,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wd,
  output logic        dev_we0,
  output logic        dev_we1,
  output logic [31:0] DR_M
);
  localparam logic [5:0] OP_LW = 6'b100011, OP_LB = 6'b100000, OP_LBU = 6'b100100,
                         OP_LH = 6'b100001, OP_LHU = 6'b100101, OP_SW = 6'b101011,
                         OP_SB = 6'b101000, OP_SH = 6'b101001;
  logic [31:0] mem [0:3071];
  logic [5:0]  op;
  logic [11:0] idx;
  logic        is_lw, is_lb, is_lbu, is_lh, is_lhu, is_sw, is_sb, is_sh;
  logic        in_ram, in_d0, in_d1, write_ok, ram_we;
  logic [3:0]  be;
  logic [31:0] wd, raw;
  logic [15:0] half;
  logic [7:0]  byte_v;
  assign op       = IR_M[31:26];
  assign idx      = AO_M[13:2];
  assign is_lw    = op == OP_LW;
  assign is_lb    = op == OP_LB;
  assign is_lbu   = op == OP_LBU;
  assign is_lh    = op == OP_LH;
  assign is_lhu   = op == OP_LHU;
  assign is_sw    = op == OP_SW;
  assign is_sb    = op == OP_SB;
  assign is_sh    = op == OP_SH;
  assign in_ram   = AO_M < 32'h0000_3000;
  assign in_d0    = AO_M >= 32'h0000_7f00 && AO_M <= 32'h0000_7f0b;
  assign in_d1    = AO_M >= 32'h0000_7f10 && AO_M <= 32'h0000_7f1b;
  assign write_ok = excode_M == 5'd0 && !flush && !reset;
  assign ram_we   = write_ok && (is_sw || is_sb || is_sh) && in_ram;
  assign dev_addr = {AO_M[31:2], 2'b00};
  assign dev_wd   = RT_M;
  assign dev_we0  = write_ok && is_sw && AO_M >= 32'h0000_7f00 && AO_M <= 32'h0000_7f07;
  assign dev_we1  = write_ok && is_sw && AO_M >= 32'h0000_7f10 && AO_M <= 32'h0000_7f17;
  always_comb begin
    be     = is_sw ? 4'hf : is_sh ? (AO_M[1] ? 4'hc : 4'h3) : is_sb ? 4'h1 << AO_M[1:0] : 4'h0;
    wd     = is_sw ? RT_M : is_sh ? {2{RT_M[15:0]}} : {4{RT_M[7:0]}};
    raw    = in_ram ? mem[idx] : in_d0 ? dev_rd0 : in_d1 ? dev_rd1 : 32'h0;
    half   = AO_M[1] ? raw[31:16] : raw[15:0];
    byte_v = raw[8*AO_M[1:0] +: 8];
    DR_M   = excode_M != 5'd0 ? 32'h0 :
             is_lw  ? raw :
             is_lh  ? {{16{half[15]}}, half} :
             is_lhu ? {16'h0, half} :
             is_lb  ? {{24{byte_v[7]}}, byte_v} :
             is_lbu ? {24'h0, byte_v} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3072; i++) mem[i] <= 32'h0;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scoreboard bench for mem_access
module tb_mem_access;
  localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001,
                         LHU = 6'b100101, SW = 6'b101011, SB = 6'b101000, SH = 6'b101001,
                         NOP = 6'b000000;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] IR_M = 0, AO_M = 0, RT_M = 0, dev_rd0 = 0, dev_rd1 = 0;
  logic [4:0]  excode_M = 0;
  logic        flush = 0;
  logic [31:0] dev_addr, dev_wd, DR_M;
  logic        dev_we0, dev_we1;
  int          checks = 0, errors = 0;
  typedef struct {
    string       tag;
    logic [31:0] dr, addr, wd;
    logic        we0, we1;
  } exp_t;
  exp_t q[$];
  mem_access dut (
    .clk(clk), .reset(reset), .IR_M(IR_M), .AO_M(AO_M), .RT_M(RT_M), .excode_M(excode_M),
    .flush(flush), .dev_rd0(dev_rd0), .dev_rd1(dev_rd1), .dev_addr(dev_addr), .dev_wd(dev_wd),
    .dev_we0(dev_we0), .dev_we1(dev_we1), .DR_M(DR_M)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [31:0] addr, input logic [31:0] rt, input logic [4:0] exc,
                      input logic fl, input logic [31:0] rd0, input logic [31:0] rd1,
                      input logic [31:0] exp_dr, input logic exp_we0, input logic exp_we1);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; IR_M = {op, 26'h0}; AO_M = addr; RT_M = rt; excode_M = exc; flush = fl;
    dev_rd0 = rd0; dev_rd1 = rd1;
    q.push_back('{tag, exp_dr, {addr[31:2], 2'b00}, rt, exp_we0, exp_we1});
    @(negedge clk);
    e = q.pop_front();
    chk({e.tag, ".dr"}, DR_M, e.dr);
    chk({e.tag, ".we0"}, {31'h0, dev_we0}, {31'h0, e.we0});
    chk({e.tag, ".we1"}, {31'h0, dev_we1}, {31'h0, e.we1});
    chk({e.tag, ".addr"}, dev_addr, e.addr);
    chk({e.tag, ".wd"}, dev_wd, e.wd);
  endtask
  initial begin
    step("rst_sw_dev",  1, SW,  32'h7f04, 32'h1,        0, 0, 0, 0, 32'h0,        0, 0);
    step("rst_lw",      1, LW,  32'h0000, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("sw4",         0, SW,  32'h0004, 32'h12345678, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lb5",         0, LB,  32'h0005, 32'h0,        0, 0, 0, 0, 32'h00000056, 0, 0);
    step("lbu7",        0, LBU, 32'h0007, 32'h0,        0, 0, 0, 0, 32'h00000012, 0, 0);
    step("lh6",         0, LH,  32'h0006, 32'h0,        0, 0, 0, 0, 32'h00001234, 0, 0);
    step("lhu4",        0, LHU, 32'h0004, 32'h0,        0, 0, 0, 0, 32'h00005678, 0, 0);
    step("sw10",        0, SW,  32'h0010, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("sb13",        0, SB,  32'h0013, 32'h000000ff, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lb13",        0, LB,  32'h0013, 32'h0,        0, 0, 0, 0, 32'hffffffff, 0, 0);
    step("lw10a",       0, LW,  32'h0010, 32'h0,        0, 0, 0, 0, 32'hff000000, 0, 0);
    step("sh10",        0, SH,  32'h0010, 32'h00008001, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lh10",        0, LH,  32'h0010, 32'h0,        0, 0, 0, 0, 32'hffff8001, 0, 0);
    step("lhu10",       0, LHU, 32'h0010, 32'h0,        0, 0, 0, 0, 32'h00008001, 0, 0);
    step("lw10b",       0, LW,  32'h0010, 32'h0,        0, 0, 0, 0, 32'hff008001, 0, 0);
    step("sh12",        0, SH,  32'h0012, 32'h0000a5c3, 0, 0, 0, 0, 32'h0,        0, 0);
    step("sb11",        0, SB,  32'h0011, 32'h00000077, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lw10c",       0, LW,  32'h0010, 32'h0,        0, 0, 0, 0, 32'ha5c37701, 0, 0);
    step("sw20",        0, SW,  32'h0020, 32'h11111111, 0, 0, 0, 0, 32'h0,        0, 0);
    step("sw20_flush",  0, SW,  32'h0020, 32'haaaaaaaa, 0, 1, 0, 0, 32'h0,        0, 0);
    step("sw20_exc",    0, SW,  32'h0020, 32'hbbbbbbbb, 5, 0, 0, 0, 32'h0,        0, 0);
    step("sb20_flush",  0, SB,  32'h0020, 32'h000000cc, 0, 1, 0, 0, 32'h0,        0, 0);
    step("lw20",        0, LW,  32'h0020, 32'h0,        0, 0, 0, 0, 32'h11111111, 0, 0);
    step("lw20_exc",    0, LW,  32'h0020, 32'h0,        4, 0, 0, 0, 32'h0,        0, 0);
    step("nop20",       0, NOP, 32'h0020, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("swdev_flush", 0, SW,  32'h7f04, 32'h5,        0, 1, 0, 0, 32'h0,        0, 0);
    step("swdev_exc",   0, SW,  32'h7f14, 32'h5,        5, 0, 0, 0, 32'h0,        0, 0);
    step("sw7f04",      0, SW,  32'h7f04, 32'hcafef00d, 0, 0, 0, 0, 32'h0,        1, 0);
    step("sw7f00",      0, SW,  32'h7f00, 32'h2,        0, 0, 0, 0, 32'h0,        1, 0);
    step("sw7f08",      0, SW,  32'h7f08, 32'h3,        0, 0, 0, 0, 32'h0,        0, 0);
    step("sb7f04",      0, SB,  32'h7f04, 32'h4,        0, 0, 0, 0, 32'h0,        0, 0);
    step("sw7f14",      0, SW,  32'h7f14, 32'h6,        0, 0, 0, 0, 32'h0,        0, 1);
    step("sw7f18",      0, SW,  32'h7f18, 32'h7,        0, 0, 0, 0, 32'h0,        0, 0);
    step("lw7f18",      0, LW,  32'h7f18, 32'h0,        0, 0, 32'h1, 32'habcd0001, 32'habcd0001, 0, 0);
    step("lw7f08",      0, LW,  32'h7f08, 32'h0,        0, 0, 32'h13572468, 32'h9, 32'h13572468, 0, 0);
    step("lb7f09",      0, LB,  32'h7f09, 32'h0,        0, 0, 32'h00008000, 32'h0, 32'hffffff80, 0, 0);
    step("lhu7f12",     0, LHU, 32'h7f12, 32'h0,        0, 0, 32'h0, 32'h80017fff, 32'h00008001, 0, 0);
    step("lw7f0c",      0, LW,  32'h7f0c, 32'h0,        0, 0, 32'hffffffff, 32'hffffffff, 32'h0, 0, 0);
    step("lw7f1c",      0, LW,  32'h7f1c, 32'h0,        0, 0, 32'hffffffff, 32'hffffffff, 32'h0, 0, 0);
    step("sw2ffc",      0, SW,  32'h2ffc, 32'h5a5a5a5a, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lw2ffc_a",    0, LW,  32'h2ffc, 32'h0,        0, 0, 0, 0, 32'h5a5a5a5a, 0, 0);
    step("sw3000",      0, SW,  32'h3000, 32'h99999999, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lw3000",      0, LW,  32'h3000, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("lw1000",      0, LW,  32'h1000, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("sw4000",      0, SW,  32'h4000, 32'h88888888, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lw4000",      0, LW,  32'h4000, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("lw0000",      0, LW,  32'h0000, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("rst_mid",     1, SW,  32'h2ffc, 32'h77777777, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lw2ffc_b",    0, LW,  32'h2ffc, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("lw4_b",       0, LW,  32'h0004, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("lw10_b",      0, LW,  32'h0010, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    step("sh2ffe",      0, SH,  32'h2ffe, 32'h0000fedc, 0, 0, 0, 0, 32'h0,        0, 0);
    step("lw2ffc_c",    0, LW,  32'h2ffc, 32'h0,        0, 0, 0, 0, 32'hfedc0000, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high; sampled on rising clk edge only.
REQ-003 SHALL: IR_M  input  32  instruction in memory stage; opcode field [31:26].
REQ-004 SHALL: AO_M  input  32  effective byte address from ALU.
REQ-005 SHALL: RT_M  input  32  store data (forwarded rt value).
REQ-006 SHALL: excode_M  input  5  exception code of this instruction; 0 = none.
REQ-007 SHALL: flush  input  1  interrupt/exception commit this cycle; 1 blocks all writes.
REQ-008 SHALL: dev_rd0  input  32  read data, timer 0 (0x7f00-0x7f0b).
REQ-009 SHALL: dev_rd1  input  32  read data, timer 1 (0x7f10-0x7f1b).
REQ-010 SHALL: dev_addr  output  32  equals AO_M with bits [1:0] forced to 0.
REQ-011 SHALL: dev_wd  output  32  equals RT_M.
REQ-012 SHALL: dev_we0  output  1  word write strobe, timer 0.
REQ-013 SHALL: dev_we1  output  1  word write strobe, timer 1.
REQ-014 SHALL: DR_M  output  32  load result, already extended, for write-back.

Function
REQ-015 SHALL: hold internal data RAM of 3072 x 32-bit words, byte range 0x0000_0000-0x0000_2fff, word index AO_M[13:2].
REQ-016 SHALL: decode opcodes lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001; all other opcodes are non-memory.
REQ-017 SHALL: define write_ok = (excode_M == 0) and (flush == 0) and (reset == 0).
REQ-018 SHALL: on rising edge with write_ok and store opcode and AO_M in RAM range, update RAM word: sw all 4 bytes; sh half selected by AO_M[1] (0 = bits 15:0, 1 = bits 31:16) with RT_M[15:0]; sb byte selected by AO_M[1:0] (0 = bits 7:0 ... 3 = bits 31:24) with RT_M[7:0]; unselected bytes unchanged.
REQ-019 SHALL: assert dev_we0 combinationally iff write_ok, opcode sw, AO_M in 0x7f00-0x7f07 (timer count register not writable); dev_we1 likewise for 0x7f10-0x7f17.
REQ-020 SHALL: never perform a RAM write and a device write in the same cycle; never write RAM for device or out-of-range addresses.
REQ-021 SHALL: produce DR_M combinationally from RAM contents before the current edge (read-old-data when a store and load to the same word coexist in one cycle cannot occur; a store in cycle N is visible to a load in cycle N+1).
REQ-022 SHALL: select raw word: RAM word for RAM range, dev_rd0 for 0x7f00-0x7f0b, dev_rd1 for 0x7f10-0x7f1b, else 0.
REQ-023 SHALL: extend DR_M: lw raw word; lh/lhu half by AO_M[1], sign-/zero-extended; lb/lbu byte by AO_M[1:0], sign-/zero-extended.
REQ-024 SHALL: drive DR_M = 0 when opcode is not a load or excode_M != 0.
REQ-025 SHALL: not check alignment itself; misaligned accesses always arrive with excode_M = 4 or 5 and are thus suppressed.
REQ-026 SHALL: have no stall or handshake; one access per cycle, zero-latency read, single-edge write.

Reset
REQ-027 SHALL: on rising edge with reset = 1, clear all 3072 RAM words to 0 in that single edge; any store in that cycle is discarded.
REQ-028 SHALL: keep dev_we0/dev_we1 = 0 while reset = 1; DR_M follows REQ-022..024 on cleared RAM (lw of RAM returns 0).
REQ-029 SHALL: treat reset asserted mid-sequence identically; no partial store survives.

Verification
REQ-030 SHALL: sw RT_M=0x12345678 @0x0004, next cycle lb @0x0005 -> DR_M=0x00000056; lbu @0x0007 -> 0x00000012; lh @0x0006 -> 0x00001234.
REQ-031 SHALL: after sw 0x00000000 @0x0010, sb RT_M=0x000000FF @0x0013, then lb @0x0013 -> 0xFFFFFFFF, lw @0x0010 -> 0xFF000000; sh RT_M=0x8001 @0x0010 then lh @0x0010 -> 0xFFFF8001, lhu -> 0x00008001.
REQ-032 SHALL: sw @0x0020 with flush=1 (or excode_M=5) -> RAM word 0x0020 unchanged, dev_we0/1 = 0.
REQ-033 SHALL: sw @0x7f04 -> dev_we0=1, dev_addr=0x00007f04; sw @0x7f08 -> dev_we0=0; sw @0x7f14 -> dev_we1=1; lw @0x7f18 with dev_rd1=0xABCD0001 -> DR_M=0xABCD0001.
REQ-034 SHALL: write 0x5A5A5A5A to 0x2ffc, assert reset one cycle, then lw 0x2ffc -> DR_M=0; lw @0x4000 (excode_M=0 forced) -> DR_M=0, no write side effects.
